// File: rtl/data_cache_pkg.sv
// Shared codes and helpers for the direct-mapped write-back data cache.
// The top and the storage array both import this package.
package data_cache_pkg;

  localparam int ADDR_WIDTH       = 17;
  localparam int LEN              = 32;
  localparam int VECTOR_SIZE      = 8;
  localparam int ENTRY_INDEX_SIZE = 3;
  localparam int CACHE_SIZE       = 16;
  localparam int CACHE_INDEX_SIZE = 4;
  localparam int TAG_WIDTH        = ADDR_WIDTH - CACHE_INDEX_SIZE - 2;

  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_BUSY = 2'b01, ST_DONE = 2'b10} status_e;
  typedef enum logic [1:0] {VIS_NONE = 2'b00, VIS_READ = 2'b01, VIS_WRITE = 2'b10} vis_e;

  localparam logic [2:0] DT_BYTE = 3'b001;
  localparam logic [2:0] DT_HALF = 3'b010;
  localparam logic [2:0] DT_WORD = 3'b011;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_DONE} state_e;

  // Byte lanes touched by a scalar store; anything that is not byte/half is a word.
  function automatic logic [3:0] store_mask(input logic [2:0] dt, input logic [1:0] off);
    case (dt)
      DT_BYTE: store_mask = 4'b0001 << off;
      DT_HALF: store_mask = off[1] ? 4'b1100 : 4'b0011;
      default: store_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [LEN-1:0] load_extract(input logic [2:0] dt, input logic [1:0] off,
                                                  input logic [LEN-1:0] line);
    logic [LEN-1:0] shifted;
    shifted = line >> {off, 3'b000};
    case (dt)
      DT_BYTE: load_extract = LEN'(shifted[7:0]);
      DT_HALF: load_extract = off[1] ? LEN'(line[31:16]) : LEN'(line[15:0]);
      default: load_extract = line;
    endcase
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// Tag/valid/dirty/data storage for the one-word-line data cache with a
// combinational hit compare; all updates target the currently addressed line.
module data_cache_array
  import data_cache_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CACHE_INDEX_SIZE-1:0] index,
  input  logic [TAG_WIDTH-1:0]        tag,
  output logic                        hit,
  output logic [LEN-1:0]              line_data,
  output logic                        victim_dirty,
  output logic [TAG_WIDTH-1:0]        victim_tag,
  input  logic                        write_en,
  input  logic [3:0]                  write_mask,
  input  logic [LEN-1:0]              write_data,
  input  logic                        install_en,
  input  logic [LEN-1:0]              install_data,
  input  logic                        clear_dirty
);

  logic [CACHE_SIZE-1:0] valid;
  logic [CACHE_SIZE-1:0] dirty;
  logic [TAG_WIDTH-1:0]  tags [CACHE_SIZE];
  logic [LEN-1:0]        data [CACHE_SIZE];

  assign hit          = valid[index] && (tags[index] == tag);
  assign line_data    = data[index];
  assign victim_dirty = valid[index] && dirty[index];
  assign victim_tag   = tags[index];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (install_en) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (write_en) begin
      dirty[index] <= 1'b1;
    end else if (clear_dirty) begin
      dirty[index] <= 1'b0;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; valid gates every use, and unreset arrays can map onto RAM.
  always_ff @(posedge clk) begin
    if (install_en) begin
      tags[index] <= tag;
      data[index] <= install_data;
    end else if (write_en) begin
      for (int b = 0; b < 4; b++)
        if (write_mask[b]) data[index][8*b +: 8] <= write_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache; vector accesses are
// sequenced as one lookup per 32-bit element against single-word lines.
module data_cache
  import data_cache_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_vis_enabled,
  input  logic [1:0]                  memory_vis_signal,
  input  logic                        is_vector,
  input  logic [2:0]                  data_type,
  input  logic [ENTRY_INDEX_SIZE:0]   vector_length,
  input  logic [ADDR_WIDTH-1:0]       mem_data_addr,
  input  logic [LEN-1:0]              mem_write_scalar_data,
  input  logic [LEN*VECTOR_SIZE-1:0]  mem_write_vector_data,
  output logic [LEN-1:0]              scalar_data,
  output logic [LEN*VECTOR_SIZE-1:0]  vector_data,
  output logic [1:0]                  mem_vis_status,
  input  logic [LEN-1:0]              mem_data,
  input  logic [1:0]                  mem_status,
  output logic [1:0]                  d_cache_mem_vis_signal,
  output logic [ADDR_WIDTH-1:0]       d_cache_mem_vis_addr,
  output logic [LEN-1:0]              mem_writen_data,
  output logic [2:0]                  write_length
);

  state_e state, next_state;

  logic                          req_write, req_vector;
  logic [2:0]                    req_type;
  logic [ENTRY_INDEX_SIZE:0]     req_len, elem;
  logic [ADDR_WIDTH-1:0]         req_addr, cur_addr;
  logic [LEN-1:0]                req_sdata;
  logic [LEN*VECTOR_SIZE-1:0]    req_vdata;
  logic [ENTRY_INDEX_SIZE-1:0]   elem_idx;

  logic                          hit, victim_dirty, lookup_hit;
  logic                          write_en, install_en, clear_dirty;
  logic [LEN-1:0]                line_data, wr_data;
  logic [3:0]                    wr_mask;
  logic [TAG_WIDTH-1:0]          victim_tag;
  logic [CACHE_INDEX_SIZE-1:0]   index;
  logic                          accept, last_elem, empty_vector;

  assign accept       = (state == S_IDLE) && mem_vis_enabled && (memory_vis_signal != VIS_NONE);
  assign elem_idx     = elem[ENTRY_INDEX_SIZE-1:0];
  assign cur_addr     = req_addr + ADDR_WIDTH'({elem, 2'b00});
  assign index        = cur_addr[CACHE_INDEX_SIZE+1:2];
  assign empty_vector = req_vector && (req_len == '0);
  assign last_elem    = !req_vector || (elem == req_len - 1'b1);

  always_comb begin
    wr_mask = store_mask(req_type, cur_addr[1:0]);
    wr_data = req_sdata;
    if (req_vector) begin
      wr_mask = 4'b1111;
      wr_data = req_vdata[LEN*elem_idx +: LEN];
    end else if (req_type == DT_BYTE) begin
      wr_data = {4{req_sdata[7:0]}};
    end else if (req_type == DT_HALF) begin
      wr_data = {2{req_sdata[15:0]}};
    end
  end

  data_cache_array u_array (
    .clk          (clk),
    .rst          (rst),
    .index        (index),
    .tag          (cur_addr[ADDR_WIDTH-1:CACHE_INDEX_SIZE+2]),
    .hit          (hit),
    .line_data    (line_data),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .write_en     (write_en),
    .write_mask   (wr_mask),
    .write_data   (wr_data),
    .install_en   (install_en),
    .install_data (mem_data),
    .clear_dirty  (clear_dirty)
  );

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path through the case can infer a latch.
  always_comb begin
    next_state             = state;
    lookup_hit             = 1'b0;
    write_en               = 1'b0;
    install_en             = 1'b0;
    clear_dirty            = 1'b0;
    mem_vis_status         = ST_IDLE;
    d_cache_mem_vis_signal = VIS_NONE;
    d_cache_mem_vis_addr   = '0;
    mem_writen_data        = '0;
    write_length           = 3'd0;
    case (state)
      S_IDLE: if (accept) next_state = S_LOOKUP;
      S_LOOKUP: begin
        mem_vis_status = ST_BUSY;
        if (empty_vector) begin
          next_state = S_DONE;
        end else if (hit) begin
          lookup_hit = 1'b1;
          write_en   = req_write;
          if (last_elem) next_state = S_DONE;
        end else begin
          next_state = victim_dirty ? S_WRITEBACK : S_REFILL;
        end
      end
      S_WRITEBACK: begin
        mem_vis_status         = ST_BUSY;
        d_cache_mem_vis_signal = VIS_WRITE;
        d_cache_mem_vis_addr   = {victim_tag, index, 2'b00};
        mem_writen_data        = line_data;
        write_length           = 3'd4;
        if (mem_status == ST_DONE) begin
          clear_dirty = 1'b1;
          next_state  = S_REFILL;
        end
      end
      S_REFILL: begin
        mem_vis_status         = ST_BUSY;
        d_cache_mem_vis_signal = VIS_READ;
        d_cache_mem_vis_addr   = {cur_addr[ADDR_WIDTH-1:2], 2'b00};
        if (mem_status == ST_DONE) begin
          install_en = 1'b1;
          next_state = S_LOOKUP;
        end
      end
      S_DONE: begin
        mem_vis_status = ST_DONE;
        next_state     = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_write   <= 1'b0;
      req_vector  <= 1'b0;
      req_type    <= '0;
      req_len     <= '0;
      req_addr    <= '0;
      req_sdata   <= '0;
      req_vdata   <= '0;
      elem        <= '0;
      scalar_data <= '0;
      vector_data <= '0;
    end else begin
      if (accept) begin
        req_write  <= (memory_vis_signal == VIS_WRITE);
        req_vector <= is_vector;
        req_type   <= data_type;
        req_len    <= (vector_length > (ENTRY_INDEX_SIZE+1)'(VECTOR_SIZE))
                      ? (ENTRY_INDEX_SIZE+1)'(VECTOR_SIZE) : vector_length;
        req_addr   <= mem_data_addr;
        req_sdata  <= mem_write_scalar_data;
        req_vdata  <= mem_write_vector_data;
        elem       <= '0;
        if (is_vector && memory_vis_signal != VIS_WRITE) vector_data <= '0;
      end
      if (lookup_hit) begin
        elem <= elem + 1'b1;
        if (!req_write) begin
          if (req_vector) vector_data[LEN*elem_idx +: LEN] <= line_data;
          else            scalar_data <= load_extract(req_type, cur_addr[1:0], line_data);
        end
      end
    end
  end

endmodule
